arm7tdmi_prefetch_unit: RTL and testbench
=========================================

// Module: arm7tdmi_prefetch_unit
// PURPOSE
//  Instruction fetch/prefetch stage directly upstream of the ARM decoder (DECODE state consumer).
//  Generates sequential fetch addresses, talks to the instruction memory port via req/ack,
//  buffers up to DEPTH fetched instructions with their PC, and redirects on flush (branch/exception/BX).
//  Supports ARM (32-bit, PC+4) and Thumb (16-bit, PC+2) fetch; tags prefetch aborts per entry.
// PARAMETERS
//  DEPTH     3             queue entries (2..8); request issued only if count+outstanding < DEPTH
//  RESET_PC  32'h0000_0000 first fetch address after reset (ARM state)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  flush        in   1   redirect fetch; discard queue and any in-flight data
//  flush_pc     in   32  new fetch address (bit0 ignored; bit1 also ignored in ARM state)
//  flush_thumb  in   1   state after redirect (1 = Thumb)
//  mem_req      out  1   fetch request, held high until mem_ack
//  mem_addr     out  32  fetch address, stable while mem_req
//  mem_size     out  1   0 = word, 1 = halfword
//  mem_ack      in   1   request complete; mem_rdata/mem_abort valid this cycle
//  mem_rdata    in   32  fetched data (halfword in [15:0] for Thumb)
//  mem_abort    in   1   prefetch abort on this access
//  dec_valid    out  1   head entry valid
//  dec_ready    in   1   decoder consumes head when dec_valid & dec_ready
//  dec_instr    out  32  instruction (Thumb: zero-extended halfword)
//  dec_pc       out  32  address of dec_instr
//  dec_thumb    out  1   entry fetched in Thumb state
//  dec_abort    out  1   entry carries prefetch abort; dec_instr = 0
// BEHAVIOUR
//  Reset: mem_req=0, mem_addr=RESET_PC, mem_size=0, dec_valid=0, dec_instr/pc=0, dec_thumb=0,
//   dec_abort=0, count=0, state=F_IDLE, fetch_pc=RESET_PC, thumb=0. Reset mid-access drops it.
//  FSM F_IDLE: if space (count<DEPTH, counting a same-cycle pop) assert mem_req -> F_WAIT.
//  F_WAIT: mem_req=1; on mem_ack push {rdata,pc,thumb,abort}, fetch_pc += thumb?2:4 (mod 2^32),
//   -> F_IDLE; next request may be issued the cycle after ack (no back-to-back in ack cycle).
//  F_DISCARD: entered on flush while in F_WAIT without ack; mem_req stays high (request not
//   withdrawn, address unchanged); on mem_ack data dropped -> F_IDLE fetching flush_pc.
//  Flush (any state, highest priority): count=0, dec_valid=0 next cycle, fetch_pc=flush_pc
//   aligned (ARM & ~3, Thumb & ~1), thumb=flush_thumb. Flush + mem_ack same cycle: data dropped,
//   -> F_IDLE. Flush + pop same cycle: pop has no effect beyond the flush.
//  Latency: mem_ack in cycle N -> dec_valid in N+1 (no bypass). Flush in N -> mem_req at new
//   address earliest N+1 (N+2+ if discard pending).
//  Push and pop same cycle: count unchanged; FIFO order strict. Pop when empty ignored.
//  Abort entries flow in order; unit keeps fetching sequentially (decoder decides).
//  No flush-to-stall: fetch stops only when queue plus outstanding reaches DEPTH.
// STRUCTURE
//  Add to arm7tdmi_pkg: typedef enum {F_IDLE,F_WAIT,F_DISCARD} fetch_state_t;
//   parameter ARM_PC_STEP=4, THUMB_PC_STEP=2; typedef struct packed fetch_entry_t
//   {instr[31:0],pc[31:0],thumb,abort}.
//  Sub-module arm7tdmi_fetch_fifo: DEPTH-entry fetch_entry_t FIFO, push/pop/clear, count,
//   wrap-around read/write pointers. FSM and PC generation stay in top.
// TESTING
//  Reset, dec_ready=1, mem_ack one cycle after each req -> mem_addr 0,4,8,...; dec_pc matches.
//  dec_ready=0, acks immediate -> exactly 3 entries buffered, mem_req low; one pop -> 1 new req.
//  Flush to 0x1001 thumb=1 while req to 0x8 outstanding; ack later -> data dropped,
//   next mem_addr=0x1000, size=1, then 0x1002; dec_thumb=1.
//  mem_abort on fetch of 0x4 -> entry dec_pc=0x4, dec_abort=1, dec_instr=0; 0x8 still fetched.
//  flush, mem_ack and pop in same cycle -> count 0, dec_valid=0 next cycle, next req at flush_pc.
//  Assert rst_n low mid-F_WAIT -> all outputs reset values immediately; restart at RESET_PC.

Source files
------------

// File: rtl/arm7tdmi_pkg.sv
// Shared types and constants for the ARM7TDMI fetch path.
package arm7tdmi_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_DISCARD
    } fetch_state_t;

    localparam logic [31:0] ARM_PC_STEP   = 32'd4;
    localparam logic [31:0] THUMB_PC_STEP = 32'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        thumb;
        logic        abort;
    } fetch_entry_t;

    // Force a fetch address onto the instruction boundary of the given state.
    function automatic logic [31:0] align_pc(input logic [31:0] pc, input logic thumb);
        return thumb ? {pc[31:1], 1'b0} : {pc[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] pc_step(input logic thumb);
        return thumb ? THUMB_PC_STEP : ARM_PC_STEP;
    endfunction

endpackage

// File: rtl/arm7tdmi_fetch_fifo.sv
// Small circular buffer holding fetched instructions between memory and decoder.
module arm7tdmi_fetch_fifo
    import arm7tdmi_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     rd_entry,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty & ~clear;
    assign do_push  = push & ~clear & ((count != FULL) | do_pop);
    assign rd_entry = mem[rd_ptr];

    // Entry storage: written on push only.
    // NOTE: storage has no reset; consumers only look at it while count says the slot is live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    // Pointer and occupancy bookkeeping; clear drops everything at once.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/arm7tdmi_prefetch_unit.sv
// Instruction prefetch stage: sequential fetch, req/ack memory port, decoder queue, flush redirect.
module arm7tdmi_prefetch_unit
    import arm7tdmi_pkg::*;
#(
    parameter int          DEPTH    = 3,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        flush_thumb,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_size,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_abort,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        dec_thumb,
    output logic        dec_abort
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [31:0]      fetch_pc;
    logic             thumb;
    logic [31:0]      disc_addr;
    logic             disc_size;
    logic             fetch_en;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] count;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // A flush in the same cycle wins over a pop, so the pop is masked here.
    assign dec_valid = ~fifo_empty;
    assign pop       = dec_valid & dec_ready & ~flush;

    // While discarding, the abandoned request keeps its original address and size.
    assign mem_addr = (state == F_DISCARD) ? disc_addr : fetch_pc;
    assign mem_size = (state == F_DISCARD) ? disc_size : thumb;

    assign wr_entry = '{
        instr: mem_abort ? 32'h0 : (thumb ? {16'h0, mem_rdata[15:0]} : mem_rdata),
        pc:    fetch_pc,
        thumb: thumb,
        abort: mem_abort
    };

    assign dec_instr = dec_valid ? head.instr : 32'h0;
    assign dec_pc    = dec_valid ? head.pc    : 32'h0;
    assign dec_thumb = dec_valid & head.thumb;
    assign dec_abort = dec_valid & head.abort;

    arm7tdmi_fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .clear    (flush),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .count    (count),
        .empty    (fifo_empty)
    );

    // Fetch FSM: issue when there is room, wait for ack, drop data of a flushed request.
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        push       = 1'b0;
        case (state)
            F_IDLE: begin
                if (fetch_en && !flush && (count < DEPTH_C || pop)) begin
                    mem_req    = 1'b1;
                    state_next = F_WAIT;
                end
            end
            F_WAIT: begin
                mem_req = 1'b1;
                if (flush) begin
                    state_next = mem_ack ? F_IDLE : F_DISCARD;
                end else if (mem_ack) begin
                    push       = 1'b1;
                    state_next = F_IDLE;
                end
            end
            F_DISCARD: begin
                mem_req = 1'b1;
                if (mem_ack) state_next = F_IDLE;
            end
            default: state_next = F_IDLE;
        endcase
    end

    // State, fetch PC and instruction-set state; fetch_en keeps mem_req low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= F_IDLE;
            fetch_pc  <= RESET_PC;
            thumb     <= 1'b0;
            disc_addr <= RESET_PC;
            disc_size <= 1'b0;
            fetch_en  <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_en <= 1'b1;
            if (flush) begin
                if (state == F_WAIT && !mem_ack) begin
                    disc_addr <= fetch_pc;
                    disc_size <= thumb;
                end
                fetch_pc <= align_pc(flush_pc, flush_thumb);
                thumb    <= flush_thumb;
            end else if (push) begin
                fetch_pc <= fetch_pc + pc_step(thumb);
            end
        end
    end

endmodule

// File: tb/tb_arm7tdmi_prefetch_unit.sv
// Self-checking bench: randomized memory latency, decoder stalls and flushes against a reference stream model.
module tb_arm7tdmi_prefetch_unit;

    localparam int          DEPTH    = 3;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        flush_thumb;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_size;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_abort;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_thumb;
    logic        dec_abort;

    arm7tdmi_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .flush_thumb (flush_thumb),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_size    (mem_size),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_abort   (mem_abort),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_thumb   (dec_thumb),
        .dec_abort   (dec_abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory contents and abort map are pure functions of the address.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic logic mem_abort_at(input logic [31:0] a);
        return (a == 32'h4) || (a[6:2] == 5'h15);
    endfunction

    // Reference: the decoder must see the sequential stream starting at the last redirect target.
    logic [31:0] exp_pc;
    logic        exp_thumb;
    int          n_pops;

    // Memory responder state.
    bit          pending;
    logic [31:0] req_addr;
    logic        req_size;
    int          lat;
    int          fix_lat = 0;
    int          req_starts;
    logic [32:0] req_log [$];
    bit          last_req;
    bit          last_valid;

    function automatic logic [31:0] log_addr(input int i);
        logic [32:0] e;
        if (i >= req_log.size()) return 32'hFFFF_FFFF;
        e = req_log[i];
        return e[31:0];
    endfunction

    function automatic logic [31:0] log_size(input int i);
        logic [32:0] e;
        if (i >= req_log.size()) return 32'hFFFF_FFFF;
        e = req_log[i];
        return 32'(e[32]);
    endfunction

    // One clock cycle: drive decoder/flush inputs, check any pop, act as memory, then take the edge.
    task automatic cycle(input bit rdy, input bit fl, input logic [31:0] fpc, input bit fth);
        logic [31:0] d;
        logic [31:0] e_instr;
        logic        e_abort;
        @(negedge clk);
        last_valid  = dec_valid;
        dec_ready   = rdy;
        flush       = fl;
        flush_pc    = fpc;
        flush_thumb = fth;
        mem_ack     = 1'b0;
        mem_abort   = 1'b0;
        mem_rdata   = 32'h0;
        #1;
        if (fl) begin
            exp_thumb = fth;
            exp_pc    = fth ? (fpc & 32'hFFFF_FFFE) : (fpc & 32'hFFFF_FFFC);
        end else if (dec_valid && rdy) begin
            d       = mem_data(exp_pc);
            e_abort = mem_abort_at(exp_pc);
            e_instr = e_abort ? 32'h0 : (exp_thumb ? (d & 32'h0000_FFFF) : d);
            check("dec_pc",    dec_pc, exp_pc);
            check("dec_instr", dec_instr, e_instr);
            check("dec_thumb", 32'(dec_thumb), 32'(exp_thumb));
            check("dec_abort", 32'(dec_abort), 32'(e_abort));
            exp_pc = exp_pc + (exp_thumb ? 32'd2 : 32'd4);
            n_pops++;
        end
        last_req = mem_req;
        if (mem_req) begin
            if (!pending) begin
                pending  = 1'b1;
                req_addr = mem_addr;
                req_size = mem_size;
                req_starts++;
                req_log.push_back({mem_size, mem_addr});
                lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
                check("req_align", 32'(mem_size ? mem_addr[0] : |mem_addr[1:0]), 32'd0);
            end else begin
                check("req_addr_stable", mem_addr, req_addr);
                check("req_size_stable", 32'(mem_size), 32'(req_size));
                if (lat == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_data(mem_addr);
                    mem_abort = mem_abort_at(mem_addr);
                end else begin
                    lat--;
                end
            end
        end else if (pending) begin
            check("req_held", 32'(mem_req), 32'd1);
            pending = 1'b0;
        end
        @(posedge clk);
        if (mem_ack) pending = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   32'(mem_req), 32'd0);
        check({tag, "_mem_addr"},  mem_addr, RESET_PC);
        check({tag, "_mem_size"},  32'(mem_size), 32'd0);
        check({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
        check({tag, "_dec_instr"}, dec_instr, 32'd0);
        check({tag, "_dec_pc"},    dec_pc, 32'd0);
        check({tag, "_dec_thumb"}, 32'(dec_thumb), 32'd0);
        check({tag, "_dec_abort"}, 32'(dec_abort), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int pops0;

        rst_n = 1'b0; dec_ready = 1'b0; flush = 1'b0; flush_pc = '0; flush_thumb = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; mem_abort = 1'b0;
        pending = 1'b0; exp_pc = RESET_PC; exp_thumb = 1'b0; n_pops = 0; req_starts = 0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential ARM fetch, ack one cycle after each request, decoder always ready.
        fix_lat = 0;
        for (int i = 0; i < 30; i++) cycle(1, 0, '0, 0);
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", log_addr(i), 32'(i * 4));
            check("seq_size", log_size(i), 32'd0);
        end
        check("seq_progress", 32'(n_pops >= 8), 32'd1);

        // Decoder stalled: queue fills to DEPTH and fetch stops; one pop allows one more.
        cycle(0, 1, 32'h0000_0100, 0);
        req_starts = 0;
        for (int i = 0; i < 15; i++) cycle(0, 0, '0, 0);
        check("fill_reqs", 32'(req_starts), 32'(DEPTH));
        check("fill_req_low", 32'(last_req), 32'd0);
        check("fill_valid", 32'(last_valid), 32'd1);
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, '0, 0);
        check("refill_reqs", 32'(req_starts), 32'(DEPTH + 1));
        check("refill_req_low", 32'(last_req), 32'd0);

        // Flush to Thumb while the request to 0x8 is still outstanding.
        fix_lat = 5;
        cycle(1, 1, 32'h0, 0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pending && req_addr == 32'h8 && lat >= 1 && lat <= 3) found = 1'b1;
            else cycle(1, 0, '0, 0);
        end
        check("thumb_flush_found", 32'(found), 32'd1);
        req_log.delete();
        pops0 = n_pops;
        cycle(1, 1, 32'h0000_1001, 1);
        for (int i = 0; i < 40; i++) cycle(1, 0, '0, 0);
        check("thumb_addr0", log_addr(0), 32'h0000_1000);
        check("thumb_size0", log_size(0), 32'd1);
        check("thumb_addr1", log_addr(1), 32'h0000_1002);
        check("thumb_size1", log_size(1), 32'd1);
        check("thumb_pops", 32'(n_pops - pops0 >= 3), 32'd1);

        // Flush, ack and pop all in one cycle.
        fix_lat = 2;
        cycle(0, 1, 32'h0000_3000, 0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pending && lat == 0 && dec_valid) found = 1'b1;
            else cycle(0, 0, '0, 0);
        end
        check("triple_found", 32'(found), 32'd1);
        req_log.delete();
        cycle(1, 1, 32'h0000_2000, 0);
        cycle(0, 0, '0, 0);
        check("triple_valid_low", 32'(last_valid), 32'd0);
        check("triple_next_addr", log_addr(0), 32'h0000_2000);
        check("triple_next_size", log_size(0), 32'd0);

        // Random traffic: stalls, latencies, redirects in both states.
        fix_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0), $urandom, $urandom_range(0, 1));
        end

        // Reset in the middle of an outstanding access.
        fix_lat = 4;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pending && lat > 1) found = 1'b1;
            else cycle(1, 0, '0, 0);
        end
        check("midreset_found", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        pending = 1'b0; mem_ack = 1'b0; exp_pc = RESET_PC; exp_thumb = 1'b0;
        dec_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_log.delete();
        pops0 = n_pops;
        fix_lat = 1;
        for (int i = 0; i < 25; i++) cycle(1, 0, '0, 0);
        check("restart_addr0", log_addr(0), RESET_PC);
        check("restart_addr1", log_addr(1), RESET_PC + 32'd4);
        check("restart_pops", 32'(n_pops - pops0 >= 3), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
